// File: rtl/axi_lite_master_bridge.sv
// axi_lite_master_bridge
//
// Converts a single-beat command interface into AXI-Lite read/write transactions,
// with one transaction outstanding at a time. AW and W are issued together; each
// command produces exactly one response pulse.
//
// Optional feature: define AXI_MST_TIMEOUT_EN to enable a handshake watchdog. Without
// it the bridge waits indefinitely for the slave.
//
// Ports:
//   ACLK, ARESETn        clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_write            1 = write, 0 = read
//   cmd_addr/cmd_wdata   command address and write data
//   rsp_valid            one-cycle response pulse (no backpressure)
//   rsp_write            response belongs to a write
//   rsp_rdata            read data (0 for writes and timeouts)
//   rsp_resp             BRESP/RRESP, or 2'b10 on timeout
//   AW/W/B/AR/R          AXI-Lite master channels, connected 1:1 to the slave
module axi_lite_master_bridge #(
  parameter int unsigned DW             = 32,
  parameter int unsigned AW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic          ACLK,
  input  logic          ARESETn,
  // Command / response side
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  output logic          rsp_write,
  output logic [DW-1:0] rsp_rdata,
  output logic [1:0]    rsp_resp,
  // Write address channel
  output logic          AWVALID,
  output logic [AW-1:0] AWADDR,
  input  logic          AWREADY,
  // Write data channel
  output logic          WVALID,
  output logic [DW-1:0] WDATA,
  input  logic          WREADY,
  // Write response channel
  input  logic          BVALID,
  input  logic [1:0]    BRESP,
  output logic          BREADY,
  // Read address channel
  output logic          ARVALID,
  output logic [AW-1:0] ARADDR,
  input  logic          ARREADY,
  // Read data channel
  input  logic          RVALID,
  input  logic [DW-1:0] RDATA,
  input  logic [1:0]    RRESP,
  output logic          RREADY
);

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdData,
    StRsp
  } state_e;

  state_e state_q;
  logic   aw_done_q;
  logic   w_done_q;

  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic ar_hs;
  logic r_hs;
  logic advance;

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;
  assign b_hs  = BVALID & BREADY;
  assign ar_hs = ARVALID & ARREADY;
  assign r_hs  = RVALID & RREADY;

  // The current wait state completes its handshake this cycle.
  always_comb begin
    advance = 1'b0;
    unique case (state_q)
      StWrReq:  advance = (aw_done_q | aw_hs) & (w_done_q | w_hs);
      StWrResp: advance = b_hs;
      StRdReq:  advance = ar_hs;
      StRdData: advance = r_hs;
      default:  advance = 1'b0;
    endcase
  end

`ifdef AXI_MST_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] tmo_q;
  logic          waiting;
  logic          tmo_hit;

  assign waiting = (state_q == StWrReq) || (state_q == StWrResp) ||
                   (state_q == StRdReq) || (state_q == StRdData);
  // Fires on the last permitted cycle of a wait state unless the handshake lands.
  assign tmo_hit = waiting && !advance && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // Cleared whenever a wait state is (re)entered, so each wait gets a full budget.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      tmo_q <= '0;
    end else if (!waiting || advance) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= StIdle;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
      AWVALID   <= 1'b0;
      AWADDR    <= '0;
      WVALID    <= 1'b0;
      WDATA     <= '0;
      BREADY    <= 1'b0;
      ARVALID   <= 1'b0;
      ARADDR    <= '0;
      RREADY    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            rsp_write <= cmd_write;
            if (cmd_write) begin
              AWADDR    <= cmd_addr;
              WDATA     <= cmd_wdata;
              AWVALID   <= 1'b1;
              WVALID    <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= StWrReq;
            end else begin
              ARADDR  <= cmd_addr;
              ARVALID <= 1'b1;
              state_q <= StRdReq;
            end
          end else begin
            // Re-arms one cycle after the response pulse.
            cmd_ready <= 1'b1;
          end
        end

        StWrReq: begin
          // AW and W complete independently, in either order or together.
          if (aw_hs) begin
            AWVALID   <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            WVALID   <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (advance) begin
            BREADY  <= 1'b1;
            state_q <= StWrResp;
          end
        end

        StWrResp: begin
          if (advance) begin
            BREADY    <= 1'b0;
            rsp_resp  <= BRESP;
            rsp_rdata <= '0;
            state_q   <= StRsp;
          end
        end

        StRdReq: begin
          if (advance) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state_q <= StRdData;
          end
        end

        StRdData: begin
          if (advance) begin
            RREADY    <= 1'b0;
            rsp_resp  <= RRESP;
            rsp_rdata <= RDATA;
            state_q   <= StRsp;
          end
        end

        StRsp: begin
          rsp_valid <= 1'b1;
          state_q   <= StIdle;
        end

        default: state_q <= StIdle;
      endcase

`ifdef AXI_MST_TIMEOUT_EN
      // Abandon the transaction and report SLVERR.
      if (tmo_hit) begin
        AWVALID   <= 1'b0;
        WVALID    <= 1'b0;
        BREADY    <= 1'b0;
        ARVALID   <= 1'b0;
        RREADY    <= 1'b0;
        rsp_resp  <= 2'b10;
        rsp_rdata <= '0;
        state_q   <= StRsp;
      end
`endif
    end
  end

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Self-checking bench for axi_lite_master_bridge: a delay-programmable AXI-Lite slave
// model, a table of command vectors, a response scoreboard and hand-written sequences
// for reset-in-flight and (when AXI_MST_TIMEOUT_EN is defined) the watchdog.
module tb_axi_lite_master_bridge;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned TMO = 8;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          AWVALID;
  logic [AW-1:0] AWADDR;
  logic          AWREADY;
  logic          WVALID;
  logic [DW-1:0] WDATA;
  logic          WREADY;
  logic          BVALID;
  logic [1:0]    BRESP;
  logic          BREADY;
  logic          ARVALID;
  logic [AW-1:0] ARADDR;
  logic          ARREADY;
  logic          RVALID;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RREADY;

  always #5 ACLK = ~ACLK;

  axi_lite_master_bridge #(
    .DW             (DW),
    .AW             (AW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .AWVALID   (AWVALID),
    .AWADDR    (AWADDR),
    .AWREADY   (AWREADY),
    .WVALID    (WVALID),
    .WDATA     (WDATA),
    .WREADY    (WREADY),
    .BVALID    (BVALID),
    .BRESP     (BRESP),
    .BREADY    (BREADY),
    .ARVALID   (ARVALID),
    .ARADDR    (ARADDR),
    .ARREADY   (ARREADY),
    .RVALID    (RVALID),
    .RDATA     (RDATA),
    .RRESP     (RRESP),
    .RREADY    (RREADY)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave model: READY/response VALID after the partner signal has been high N cycles.
  int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [31:0] s_rdata;
  logic [1:0]  s_resp;

  always @(negedge ACLK) begin
    if (AWVALID) begin
      if (aw_cnt >= aw_dly) AWREADY = 1'b1;
      else begin AWREADY = 1'b0; aw_cnt++; end
    end else begin AWREADY = 1'b0; aw_cnt = 0; end
    if (WVALID) begin
      if (w_cnt >= w_dly) WREADY = 1'b1;
      else begin WREADY = 1'b0; w_cnt++; end
    end else begin WREADY = 1'b0; w_cnt = 0; end
    if (BREADY) begin
      if (b_cnt >= b_dly) begin BVALID = 1'b1; BRESP = s_resp; end
      else begin BVALID = 1'b0; b_cnt++; end
    end else begin BVALID = 1'b0; b_cnt = 0; end
    if (ARVALID) begin
      if (ar_cnt >= ar_dly) ARREADY = 1'b1;
      else begin ARREADY = 1'b0; ar_cnt++; end
    end else begin ARREADY = 1'b0; ar_cnt = 0; end
    if (RREADY) begin
      if (r_cnt >= r_dly) begin RVALID = 1'b1; RDATA = s_rdata; RRESP = s_resp; end
      else begin RVALID = 1'b0; r_cnt++; end
    end else begin RVALID = 1'b0; r_cnt = 0; end
  end

  // Scoreboard
  typedef struct {
    logic        write;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        aw_seen, w_seen, bready_prev, rsp_chk_next;
  int          bready_cyc, arvalid_cyc, rsp_cnt;

  always @(posedge ACLK) begin
    if (cmd_valid && cmd_ready) begin
      aw_seen     = 1'b0;
      w_seen      = 1'b0;
      bready_cyc  = 0;
      arvalid_cyc = 0;
    end
    if (AWVALID && AWREADY) begin
      aw_seen = 1'b1;
      check("awaddr", AWADDR, cur_addr);
    end
    if (WVALID && WREADY) begin
      w_seen = 1'b1;
      check("wdata", WDATA, cur_wdata);
    end
    if (ARVALID && ARREADY) check("araddr", ARADDR, cur_addr);
  end

  always @(negedge ACLK) begin
    exp_t e;
    if (BREADY) bready_cyc++;
    if (ARVALID) arvalid_cyc++;
    if (BREADY && !bready_prev) check("bready_after_aw_w", {aw_seen, w_seen}, 2'b11);
    bready_prev = BREADY;
    if (rsp_chk_next) begin
      // Pulse lasts one cycle and cmd_ready returns right after it.
      check("rsp_pulse_then_ready", {rsp_valid, cmd_ready}, 2'b01);
      rsp_chk_next = 1'b0;
    end else if (rsp_valid) begin
      rsp_cnt++;
      rsp_chk_next = 1'b1;
      check("rsp_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rsp_write", rsp_write, e.write);
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_resp", rsp_resp, e.resp);
        check("cmd_ready_low_in_rsp", cmd_ready, 1'b0);
      end
    end
  end

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          aw_d, w_d, b_d, ar_d, r_d;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge ACLK); #1;
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1'b1);
  endtask

  task automatic run_cmd(input vec_t v, input int budget);
    exp_t e;
    int   start;
    int   n;
    aw_dly = v.aw_d; w_dly = v.w_d; b_dly = v.b_d; ar_dly = v.ar_d; r_dly = v.r_d;
    s_rdata = v.rdata; s_resp = v.resp;
    cur_addr = v.addr; cur_wdata = v.wdata;
    wait_ready();
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
    e.write = v.write; e.rdata = v.exp_rdata; e.resp = v.exp_resp;
    exp_q.push_back(e);
    start = rsp_cnt;
    @(posedge ACLK);
    @(negedge ACLK); #1;
    cmd_valid = 1'b0;
    check("valid_after_accept", {AWVALID, WVALID, ARVALID, cmd_ready},
          v.write ? 4'b1100 : 4'b0010);
    n = 0;
    while (rsp_cnt == start && n < budget) begin
      @(negedge ACLK); #1;
      n++;
    end
    check("rsp_arrived", rsp_cnt != start, 1'b1);
  endtask

  vec_t vecs[8];

  initial begin
    vec_t v;
    ARESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    s_rdata = '0; s_resp = 2'b00; cur_addr = '0; cur_wdata = '0;
    aw_seen = 1'b0; w_seen = 1'b0; bready_prev = 1'b0; rsp_chk_next = 1'b0;
    bready_cyc = 0; arvalid_cyc = 0; rsp_cnt = 0;

    //         wr    addr          wdata         aw w  b  ar r  rdata         resp   exp_rdata     exp_resp
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1, 1, 0, 0, 0, 32'h0,         2'b00, 32'h0,         2'b00};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         0, 0, 0, 1, 0, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 2'b00};
    vecs[2] = '{1'b1, 32'h0000_0020, 32'h1111_2222, 4, 1, 0, 0, 0, 32'h0,         2'b00, 32'h0,         2'b00};
    vecs[3] = '{1'b1, 32'h0000_0024, 32'h3333_4444, 0, 0, 0, 0, 0, 32'h0,         2'b01, 32'h0,         2'b01};
    vecs[4] = '{1'b1, 32'h0000_0028, 32'h5555_6666, 1, 1, 5, 0, 0, 32'h0,         2'b10, 32'h0,         2'b10};
    vecs[5] = '{1'b0, 32'h0000_0044, 32'h0,         0, 0, 0, 3, 2, 32'h1234_5678, 2'b11, 32'h1234_5678, 2'b11};
    vecs[6] = '{1'b1, 32'h0000_0030, 32'h7777_8888, 0, 3, 0, 0, 0, 32'h0,         2'b00, 32'h0,         2'b00};
    vecs[7] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         0, 0, 0, 0, 0, 32'hA5A5_5A5A, 2'b00, 32'hA5A5_5A5A, 2'b00};

    repeat (3) @(negedge ACLK);
    check("reset_ctrl", {cmd_ready, rsp_valid, rsp_write, AWVALID, WVALID, BREADY, ARVALID,
                         RREADY, rsp_resp}, 10'b10_0000_0000);
    check("reset_rdata_araddr", {rsp_rdata, ARADDR}, 64'h0);
    check("reset_awaddr_wdata", {AWADDR, WDATA}, 64'h0);
    #1 ARESETn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_cmd(vecs[i], 100);
      if (vecs[i].write) check($sformatf("bready_cycles_%0d", i), bready_cyc, vecs[i].b_d + 1);
      else check($sformatf("arvalid_cycles_%0d", i), arvalid_cyc, vecs[i].ar_d + 1);
    end

    // Reset while a read address is pending: no response, outputs back to reset values.
    ar_dly = 1000; cur_addr = 32'h0000_0080;
    wait_ready();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0080;
    @(posedge ACLK);
    @(negedge ACLK); #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge ACLK);
    #1 check("arvalid_before_reset", ARVALID, 1'b1);
    #2 ARESETn = 1'b0;
    #1;
    check("midrst_ctrl", {cmd_ready, rsp_valid, rsp_write, AWVALID, WVALID, BREADY, ARVALID,
                          RREADY, rsp_resp}, 10'b10_0000_0000);
    check("midrst_rdata_araddr", {rsp_rdata, ARADDR}, 64'h0);
    @(negedge ACLK); #1 ARESETn = 1'b1;
    repeat (2) @(negedge ACLK);
    #1;
    v = '{1'b0, 32'h0000_0010, 32'h0, 0, 0, 0, 0, 1, 32'hCAFE_F00D, 2'b00, 32'hCAFE_F00D, 2'b00};
    run_cmd(v, 100);
    v = '{1'b1, 32'h0000_0014, 32'h0BAD_CAFE, 2, 2, 1, 0, 0, 32'h0, 2'b00, 32'h0, 2'b00};
    run_cmd(v, 100);

`ifdef AXI_MST_TIMEOUT_EN
    // ARREADY never arrives: ARVALID holds for TMO cycles, then SLVERR.
    v = '{1'b0, 32'h0000_0050, 32'h0, 0, 0, 0, 1000, 0, 32'h0, 2'b00, 32'h0, 2'b10};
    run_cmd(v, 100);
    check("timeout_arvalid_cycles", arvalid_cyc, TMO);
    check("timeout_arvalid_low", ARVALID, 1'b0);
    // BVALID never arrives after both address/data handshakes.
    v = '{1'b1, 32'h0000_0054, 32'h1, 0, 0, 1000, 0, 0, 32'h0, 2'b00, 32'h0, 2'b10};
    run_cmd(v, 100);
    check("timeout_bready_cycles", bready_cyc, TMO);
`endif

    repeat (5) @(negedge ACLK);
    #1 check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
